// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: bus widths, I/O window, access size codes,
// controller states and requester identities (listed in grant priority order).
package mem_arbiter_pkg;

    localparam int          ADDR_WIDTH = 32;
    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] IO_ADDR    = 32'h30000;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    // Highest grant priority first: committed stores, then loads, then fetch.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_STORE,
        OWN_LOAD,
        OWN_FETCH
    } owner_t;

    // The UART and other devices live where address bits [17:16] are both set.
    function automatic logic isIoAddr(input logic [ADDR_WIDTH-1:0] addr);
        return addr[17:16] == IO_ADDR[17:16];
    endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Builds a 32-bit load result from the assembled little-endian byte buffer,
// sign- or zero-extending from the top byte actually read.
module mem_arbiter_load_extend
    import mem_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] byteBuf_i,
    input  logic [2:0]            size_i,
    input  logic                  isSigned_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    always_comb begin
        result_o = byteBuf_i;
        case (size_i)
            SIZE_BYTE: result_o = {{24{isSigned_i & byteBuf_i[7]}}, byteBuf_i[7:0]};
            SIZE_HALF: result_o = {{16{isSigned_i & byteBuf_i[15]}}, byteBuf_i[15:0]};
            SIZE_WORD: result_o = byteBuf_i;
            default:   result_o = byteBuf_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial single-port memory controller shared by fetch, loads and committed stores.
// Define IO_BUF_STALL_EN to hold I/O write bytes while the UART buffer is full.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_data,
    input  logic                  lsb_req,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [5:0]            lsb_size,
    input  logic                  lsb_signed,
    output logic                  lsb_done,
    output logic [DATA_WIDTH-1:0] lsb_data,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [5:0]            st_size,
    output logic                  st_done
);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;

    logic                  ifPend_q, ifPend_d;
    logic [ADDR_WIDTH-1:0] ifAddr_q, ifAddr_d;
    logic                  ldPend_q, ldPend_d;
    logic [ADDR_WIDTH-1:0] ldAddr_q, ldAddr_d;
    logic [2:0]            ldSize_q, ldSize_d;
    logic                  ldSigned_q, ldSigned_d;
    logic                  stPend_q, stPend_d;
    logic [ADDR_WIDTH-1:0] stAddr_q, stAddr_d;
    logic [DATA_WIDTH-1:0] stData_q, stData_d;
    logic [2:0]            stSize_q, stSize_d;

    logic                  ifDone_q, ifDone_d;
    logic [DATA_WIDTH-1:0] ifData_q, ifData_d;
    logic                  ldDone_q, ldDone_d;
    logic [DATA_WIDTH-1:0] ldData_q, ldData_d;
    logic                  stDone_q, stDone_d;

    logic                  ifAccept, ldAccept, stAccept;
    logic                  ifValid, ldValid, stValid;
    logic [ADDR_WIDTH-1:0] ifAddrEff, ldAddrEff, stAddrEff;
    logic [2:0]            ldSizeEff, stSizeEff;
    logic                  ldSignedEff;
    logic [DATA_WIDTH-1:0] stDataEff;
    logic [ADDR_WIDTH-1:0] busAddr;
    logic [1:0]            capIdx;
    logic [DATA_WIDTH-1:0] bufMerged;
    logic [DATA_WIDTH-1:0] extResult;
    logic                  ioStall;
    logic [2:0]            unusedSizeHi;

    assign unusedSizeHi = st_size[5:3] | lsb_size[5:3];

    // Fetch/load pulses are dropped by a flush; a store pulse in a flush cycle still lands.
    assign ifAccept = rdy && if_req && !ifPend_q && !clear;
    assign ldAccept = rdy && lsb_req && !ldPend_q && !clear;
    assign stAccept = rdy && st_req && !stPend_q;

    assign ifValid = (ifPend_q && !clear) || ifAccept;
    assign ldValid = (ldPend_q && !clear) || ldAccept;
    assign stValid = stPend_q || stAccept;

    assign ifAddrEff   = ifAccept ? if_addr        : ifAddr_q;
    assign ldAddrEff   = ldAccept ? lsb_addr       : ldAddr_q;
    assign ldSizeEff   = ldAccept ? lsb_size[2:0]  : ldSize_q;
    assign ldSignedEff = ldAccept ? lsb_signed     : ldSigned_q;
    assign stAddrEff   = stAccept ? st_addr        : stAddr_q;
    assign stDataEff   = stAccept ? st_data        : stData_q;
    assign stSizeEff   = stAccept ? st_size[2:0]   : stSize_q;

    assign busAddr = base_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
    // Read data lags the address by one cycle, so counter value c carries byte c-1.
    assign capIdx  = cnt_q[1:0] - 2'd1;

`ifdef IO_BUF_STALL_EN
    assign ioStall = (state_q == ST_WRITE) && isIoAddr(busAddr) && io_buffer_full;
`else
    logic unusedIoFull;
    assign unusedIoFull = io_buffer_full;
    assign ioStall      = 1'b0;
`endif

    always_comb begin
        bufMerged = buf_q;
        bufMerged[{capIdx, 3'b000} +: 8] = mem_din;
    end

    mem_arbiter_load_extend u_load_extend (
        .byteBuf_i  (bufMerged),
        .size_i     (size_q),
        .isSigned_i (signed_q),
        .result_o   (extResult)
    );

    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        case (state_q)
            ST_READ: mem_a = busAddr;
            ST_WRITE: begin
                mem_a    = busAddr;
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = !ioStall;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        size_d     = size_q;
        signed_d   = signed_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        ifPend_d   = ifPend_q && !clear;
        ifAddr_d   = ifAddr_q;
        ldPend_d   = ldPend_q && !clear;
        ldAddr_d   = ldAddr_q;
        ldSize_d   = ldSize_q;
        ldSigned_d = ldSigned_q;
        stPend_d   = stPend_q;
        stAddr_d   = stAddr_q;
        stData_d   = stData_q;
        stSize_d   = stSize_q;
        ifDone_d   = 1'b0;
        ifData_d   = ifData_q;
        ldDone_d   = 1'b0;
        ldData_d   = ldData_q;
        stDone_d   = 1'b0;

        if (ifAccept) begin
            ifPend_d = 1'b1;
            ifAddr_d = if_addr;
        end
        if (ldAccept) begin
            ldPend_d   = 1'b1;
            ldAddr_d   = lsb_addr;
            ldSize_d   = lsb_size[2:0];
            ldSigned_d = lsb_signed;
        end
        if (stAccept) begin
            stPend_d = 1'b1;
            stAddr_d = st_addr;
            stData_d = st_data;
            stSize_d = st_size[2:0];
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                buf_d = '0;
                if (stValid) begin
                    state_d  = ST_WRITE;
                    owner_d  = OWN_STORE;
                    base_d   = stAddrEff;
                    size_d   = stSizeEff;
                    wdata_d  = stDataEff;
                    stPend_d = 1'b0;
                end else if (ldValid) begin
                    state_d  = ST_READ;
                    owner_d  = OWN_LOAD;
                    base_d   = ldAddrEff;
                    size_d   = ldSizeEff;
                    signed_d = ldSignedEff;
                    ldPend_d = 1'b0;
                end else if (ifValid) begin
                    state_d  = ST_READ;
                    owner_d  = OWN_FETCH;
                    base_d   = ifAddrEff;
                    size_d   = SIZE_WORD;
                    signed_d = 1'b0;
                    ifPend_d = 1'b0;
                end
            end
            ST_READ: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d = bufMerged;
                    end
                    if (cnt_q == size_q) begin
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                        cnt_d   = '0;
                        if (owner_q == OWN_FETCH) begin
                            ifDone_d = 1'b1;
                            ifData_d = extResult;
                        end else begin
                            ldDone_d = 1'b1;
                            ldData_d = extResult;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (!ioStall) begin
                    if (cnt_q == size_q - 3'd1) begin
                        state_d  = ST_IDLE;
                        owner_d  = OWN_NONE;
                        cnt_d    = '0;
                        stDone_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rdy low freezes every register, including the done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            cnt_q      <= '0;
            base_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
            buf_q      <= '0;
            ifPend_q   <= 1'b0;
            ifAddr_q   <= '0;
            ldPend_q   <= 1'b0;
            ldAddr_q   <= '0;
            ldSize_q   <= '0;
            ldSigned_q <= 1'b0;
            stPend_q   <= 1'b0;
            stAddr_q   <= '0;
            stData_q   <= '0;
            stSize_q   <= '0;
            ifDone_q   <= 1'b0;
            ifData_q   <= '0;
            ldDone_q   <= 1'b0;
            ldData_q   <= '0;
            stDone_q   <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            ifPend_q   <= ifPend_d;
            ifAddr_q   <= ifAddr_d;
            ldPend_q   <= ldPend_d;
            ldAddr_q   <= ldAddr_d;
            ldSize_q   <= ldSize_d;
            ldSigned_q <= ldSigned_d;
            stPend_q   <= stPend_d;
            stAddr_q   <= stAddr_d;
            stData_q   <= stData_d;
            stSize_q   <= stSize_d;
            ifDone_q   <= ifDone_d;
            ifData_q   <= ifData_d;
            ldDone_q   <= ldDone_d;
            ldData_q   <= ldData_d;
            stDone_q   <= stDone_d;
        end
    end

    assign if_done  = ifDone_q;
    assign if_data  = ifData_q;
    assign lsb_done = ldDone_q;
    assign lsb_data = ldData_q;
    assign st_done  = stDone_q;

endmodule
